ev_counter_multi: RTL

- Parametrised multi-channel successor of the single-channel event counter.
- Each of CH_NUM asynchronous event inputs (buttons/switches) passes through a synchroniser and a per-channel edge detector, with a selectable edge mode, and drives its own CNT_W-bit counter.
- Per-channel enable, clear, wrap/saturate policy, sticky overflow flags, and a global snapshot register bank.
- One channel is selected onto the display data path.

---
 rtl/ev_counter_multi.sv | 116 +++++++++++
 1 files changed

// File: rtl/ev_counter_multi.sv
// Multi-channel event counter with per-channel edge detect, enable,
// clear, overflow flags and a global snapshot bank.
module ev_counter_multi #(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0,
    localparam int SEL_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CH_NUM-1:0]   ev_i,
    input  logic [CH_NUM-1:0]   en_i,
    input  logic [CH_NUM-1:0]   clr_i,
    input  logic [2*CH_NUM-1:0] mode_i,
    input  logic                snap_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [CNT_W-1:0]    snap_o,
    output logic [CH_NUM-1:0]   ovf_o
);

    localparam int ARM_N = SYNC_STAGES + 1;
    localparam int ARM_W = $clog2(ARM_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ARM_W-1:0]  arm_q;
    logic              armed;
    logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
    logic [CH_NUM-1:0] prev_q;
    logic [CH_NUM-1:0] rise;
    logic [CH_NUM-1:0] fall;
    logic [CH_NUM-1:0] hit;
    logic [CNT_W-1:0]  cnt_q  [CH_NUM];
    logic [CNT_W-1:0]  snap_q [CH_NUM];
    logic [CH_NUM-1:0] ovf_q;

    // Edges are ignored until the sync chain and prev hold post-reset samples
    assign armed = (arm_q == ARM_W'(ARM_N));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arm_q <= '0;
        end else if (!armed) begin
            arm_q <= arm_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= ev_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

    always_comb begin
        hit = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            hit[n] = armed & en_i[n]
                   & ((mode_i[2*n] & rise[n]) | (mode_i[2*n+1] & fall[n]));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < CH_NUM; n++) begin
                cnt_q[n]  <= '0;
                snap_q[n] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int n = 0; n < CH_NUM; n++) begin
                if (snap_i) begin
                    snap_q[n] <= cnt_q[n];
                end
                if (clr_i[n]) begin
                    cnt_q[n] <= '0;
                    ovf_q[n] <= 1'b0;
                end else if (hit[n]) begin
                    if (cnt_q[n] == CNT_MAX) begin
                        ovf_q[n] <= 1'b1;
                        cnt_q[n] <= (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        cnt_q[n] <= cnt_q[n] + 1'b1;
                    end
                end
            end
        end
    end

    // Out-of-range selects fall through to zero
    always_comb begin
        cnt_o  = '0;
        snap_o = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            if (int'(sel_i) == n) begin
                cnt_o  = cnt_q[n];
                snap_o = snap_q[n];
            end
        end
    end

    assign ovf_o = ovf_q;

endmodule
